coreaxi4dma_multibank_cache: RTL and testbench
==============================================

Name: coreaxi4dma_multibank_cache

Overview:
- Generalised successor to the DMA ping-pong cache: NUM_BANKS independent RAM banks (2..8), each CACHE_DEPTH x CACHE_WIDTH bytes.
- A per-bank state machine runs the banks as an in-order ring. The DMA write side fills one bank while the AXI4 master side drains earlier committed banks.
- Tracks bytes per bank, gives 2-cycle registered read data with a valid strobe, qualifies ECC flags to read beats, and flags protocol misuse.

Parameters:
- CACHE_WIDTH, 8, bank width in bytes (AXI data bus bytes, power of 2, 1..64).
- CACHE_DEPTH, 16, locations per bank (2..256).
- NUM_BANKS, 4, bank count (2..8).
- ECC, 1, 1 = ECC RAM with SB/DB flags; 0 = flags tied 0.
- Derived: AW = clog2(CACHE_DEPTH); BW = clog2(NUM_BANKS); TW = clog2(CACHE_WIDTH)+1; CW = clog2(CACHE_DEPTH*CACHE_WIDTH+1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  sync clear: all banks FREE, counts 0, pointers 0.
- wrEn  in  1  write beat request.
- wrAddr  in  AW  location in current write bank.
- wrData  in  CACHE_WIDTH*8  write beat data.
- wrByteCnt  in  TW  valid bytes in beat (0..CACHE_WIDTH).
- wrCommit  in  1  close current write bank and hand it to read side.
- rdEn  in  1  read beat request.
- rdAddr  in  AW  location in current read bank.
- rdByteCnt  in  TW  bytes consumed by beat.
- rdRelease  in  1  current read bank fully consumed; free it.
- wrBankSel  out  BW  bank index the write side is targeting.
- rdBankSel  out  BW  bank index the read side is targeting.
- wrReady  out  1  write bank is FREE or FILL.
- rdReady  out  1  read bank is READY or DRAIN.
- wrBankByteCnt  out  CW  byte count of write bank.
- rdBankByteCnt  out  CW  byte count of read bank.
- freeBanks  out  BW+1  number of FREE banks.
- rdData  out  CACHE_WIDTH*8  read data.
- rdValid  out  1  rdData valid strobe.
- protoErr  out  3  one-cycle pulses: [0] write dropped, [1] read dropped/underflow, [2] empty commit.
- error_flag_sb_cache  out  1  single-bit corrected, aligned to rdValid.
- error_flag_db_cache  out  1  double-bit detected, aligned to rdValid.

Behaviour:
- Reset values: all banks FREE, wrBankSel=rdBankSel=0, counts 0, freeBanks=NUM_BANKS, wrReady=1, rdReady=0, rdValid=0, rdData=0, protoErr=0, ECC flags 0.
- Bank states are FREE, FILL, READY and DRAIN.
  - FREE->FILL on first accepted write.
  - FILL->READY on wrCommit with count>0.
  - READY->DRAIN on first accepted read.
  - READY/DRAIN->FREE on rdRelease.
- Write acceptance: wrEn && wrReady. The RAM is written, and the count increments by wrByteCnt, saturating at CACHE_DEPTH*CACHE_WIDTH. wrEn && !wrReady drops the beat and pulses protoErr[0].
- wrCommit in FILL with count>0: the bank goes READY and wrBankSel advances modulo NUM_BANKS. In FREE, or with count 0, nothing changes and protoErr[2] pulses.
  - Same-cycle wrEn and wrCommit: the write lands and counts first, then the commit applies. A FREE bank with a write in the same cycle commits with the new count.
- Read acceptance: rdEn && rdReady. The RAM read is issued and the count decrements by rdByteCnt, floored at 0. If rdByteCnt exceeds the count, protoErr[1] pulses. rdEn && !rdReady pulses protoErr[1], and no rdValid follows.
- Read latency: rdValid asserts exactly 2 cycles after an accepted rdEn, and rdData holds until the next rdValid.
  - ECC flags are registered with rdValid and are 0 when rdValid=0.
  - Back-to-back reads give back-to-back rdValid.
- rdRelease on a READY/DRAIN bank: the bank goes FREE, its count clears and rdBankSel advances. On a FREE/FILL bank it is ignored and protoErr[1] pulses.
  - Same-cycle rdEn and rdRelease: the read issues, then the bank is freed.
  - Reads still in the 2-cycle pipeline complete normally.
- Simultaneous write-bank and read-bank count updates on different banks are independent. When wrBankSel==rdBankSel, the states are mutually exclusive (FILL vs READY/DRAIN), so no bank is both written and read.
- Ring full: when all banks are READY/DRAIN, wrReady=0. When all banks are FREE/FILL, rdReady=0.
- freeBanks updates on the cycle after each state change (registered).
- flush has priority over all same-cycle requests. It also squashes the in-flight rdValid and its ECC flags.
- reset asserted mid-transfer clears state immediately (async). RAM contents are not cleared.

Test Plan:
- NUM_BANKS=4, CACHE_WIDTH=8: write 4 beats of 8 bytes to bank 0, then commit → wrBankSel=1, rdReady=1, rdBankByteCnt=32. Read 4 beats of 8 → rdValid 2 cycles after each rdEn with matching data, count reaches 0. Release → freeBanks=4.
- Commit banks 0..3 without reading → wrReady=0. A further wrEn pulses protoErr[0]. Releasing bank 0 → wrReady=1 and wrBankSel=0 (wrap).
- wrCommit with count 0 → protoErr[2]=1 for 1 cycle, state unchanged. Same-cycle wrEn(5 bytes)+wrCommit on a FREE bank → bank READY with count 5.
- Bank holds 3 bytes, rdByteCnt=8 → count 0, protoErr[1] pulse. rdEn with rdReady=0 → protoErr[1], no rdValid.
- Inject SB error at addr 2 → error_flag_sb_cache high only on the rdValid cycle of that read. DB injection → error_flag_db_cache likewise.
- flush with a read in flight and two banks READY → rdValid stays 0, all counts 0, pointers 0, freeBanks=4. Async reset mid-write → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/coreaxi4dma_multibank_cache_if.sv
// coreaxi4dma_multibank_cache_if: request/response bundle between the DMA
// write side, the AXI4 read side and the multi-bank cache.
interface coreaxi4dma_multibank_cache_if #(
  parameter int CACHE_WIDTH = 8,
  parameter int CACHE_DEPTH = 16,
  parameter int NUM_BANKS   = 4
);
  localparam int AW = $clog2(CACHE_DEPTH);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int TW = $clog2(CACHE_WIDTH) + 1;
  localparam int CW = $clog2(CACHE_DEPTH * CACHE_WIDTH + 1);
  localparam int DW = CACHE_WIDTH * 8;

  logic          flush;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic [TW-1:0] wrByteCnt;
  logic          wrCommit;
  logic [1:0]    wrEccInj;
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic [TW-1:0] rdByteCnt;
  logic          rdRelease;

  logic [BW-1:0] wrBankSel;
  logic [BW-1:0] rdBankSel;
  logic          wrReady;
  logic          rdReady;
  logic [CW-1:0] wrBankByteCnt;
  logic [CW-1:0] rdBankByteCnt;
  logic [BW:0]   freeBanks;
  logic [DW-1:0] rdData;
  logic          rdValid;
  logic [2:0]    protoErr;
  logic          error_flag_sb_cache;
  logic          error_flag_db_cache;

  modport master (
    output flush, wrEn, wrAddr, wrData, wrByteCnt, wrCommit, wrEccInj,
    output rdEn, rdAddr, rdByteCnt, rdRelease,
    input  wrBankSel, rdBankSel, wrReady, rdReady,
    input  wrBankByteCnt, rdBankByteCnt, freeBanks,
    input  rdData, rdValid, protoErr,
    input  error_flag_sb_cache, error_flag_db_cache
  );

  modport slave (
    input  flush, wrEn, wrAddr, wrData, wrByteCnt, wrCommit, wrEccInj,
    input  rdEn, rdAddr, rdByteCnt, rdRelease,
    output wrBankSel, rdBankSel, wrReady, rdReady,
    output wrBankByteCnt, rdBankByteCnt, freeBanks,
    output rdData, rdValid, protoErr,
    output error_flag_sb_cache, error_flag_db_cache
  );
endinterface

// File: rtl/coreaxi4dma_multibank_cache.sv
// coreaxi4dma_multibank_cache: ring of NUM_BANKS RAM banks filled by DMA
// writes and drained by AXI4 reads, with optional SECDED-protected storage.
module coreaxi4dma_multibank_cache #(
  parameter int CACHE_WIDTH = 8,
  parameter int CACHE_DEPTH = 16,
  parameter int NUM_BANKS   = 4,
  parameter int ECC         = 1
) (
  input logic                          clock,
  input logic                          reset,
  coreaxi4dma_multibank_cache_if.slave bus
);

  function automatic int f_pbits(input int k);
    int r;
    r = 1;
    while ((1 << r) < (k + r + 1)) r++;
    return r;
  endfunction

  localparam int AW   = $clog2(CACHE_DEPTH);
  localparam int BW   = $clog2(NUM_BANKS);
  localparam int CW   = $clog2(CACHE_DEPTH * CACHE_WIDTH + 1);
  localparam int DW   = CACHE_WIDTH * 8;
  localparam int MAXB = CACHE_DEPTH * CACHE_WIDTH;
  localparam int PB   = f_pbits(DW);
  localparam int NH   = DW + PB;
  localparam int CWB  = NH + 1;
  localparam int MW   = (ECC != 0) ? CWB : DW;

  typedef enum logic [1:0] {
    S_FREE,
    S_FILL,
    S_READY,
    S_DRAIN
  } state_t;

  // Hamming code over positions 1..NH, bit 0 holds overall parity.
  function automatic logic [CWB-1:0] f_enc(input logic [DW-1:0] d);
    logic [CWB-1:0] c;
    logic [PB-1:0]  s;
    int             j;
    c = '0;
    s = '0;
    j = 0;
    for (int p = 1; p <= NH; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int p = 1; p <= NH; p++)
      if (c[p]) s ^= p[PB-1:0];
    for (int k = 0; k < PB; k++)
      c[1 << k] = s[k];
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [DW+1:0] f_dec(input logic [CWB-1:0] c);
    logic [CWB-1:0] x;
    logic [PB-1:0]  s;
    logic [DW-1:0]  d;
    logic           par;
    int             j;
    x   = c;
    s   = '0;
    d   = '0;
    j   = 0;
    par = ^c;
    for (int p = 1; p <= NH; p++)
      if (x[p]) s ^= p[PB-1:0];
    if (par && (s != '0) && (int'(s) <= NH))
      x[s] = ~x[s];
    for (int p = 1; p <= NH; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = x[p];
        j++;
      end
    end
    return {(!par && (s != '0)), par, d};
  endfunction

  function automatic logic [BW-1:0] f_next(input logic [BW-1:0] s);
    return (s == BW'(NUM_BANKS - 1)) ? '0 : s + BW'(1);
  endfunction

  state_t        r_st  [NUM_BANKS];
  logic [CW-1:0] r_cnt [NUM_BANKS];
  logic [BW-1:0] r_wsel;
  logic [BW-1:0] r_rsel;
  logic [BW:0]   r_free;
  logic [2:0]    r_perr;
  logic          r_v1;
  logic          r_valid;
  logic [DW-1:0] r_rdata;
  logic          r_sb;
  logic          r_db;
  logic [MW-1:0] r_rd_word;
  logic [MW-1:0] r_mem [NUM_BANKS][CACHE_DEPTH];

  state_t        n_st  [NUM_BANKS];
  logic [CW-1:0] n_cnt [NUM_BANKS];
  logic [BW-1:0] n_wsel;
  logic [BW-1:0] n_rsel;
  logic [2:0]    n_perr;
  logic [BW:0]   n_free;
  logic [CW:0]   w_sum;

  logic          w_wr_ready;
  logic          w_rd_ready;
  logic          w_wacc;
  logic          w_racc;
  logic [MW-1:0] w_wr_word;
  logic [DW-1:0] w_rd_data;
  logic          w_sb;
  logic          w_db;

  assign w_wr_ready = (r_st[r_wsel] == S_FREE) || (r_st[r_wsel] == S_FILL);
  assign w_rd_ready = (r_st[r_rsel] == S_READY) || (r_st[r_rsel] == S_DRAIN);
  assign w_wacc     = bus.wrEn && w_wr_ready && !bus.flush;
  assign w_racc     = bus.rdEn && w_rd_ready && !bus.flush;

  generate
    if (ECC != 0) begin : g_ecc
      // wrEccInj corrupts the stored word: [0] one data bit, [1] two.
      always_comb begin
        w_wr_word = f_enc(bus.wrData);
        if (bus.wrEccInj[0]) w_wr_word[3] = ~w_wr_word[3];
        if (bus.wrEccInj[1]) begin
          w_wr_word[3] = ~w_wr_word[3];
          w_wr_word[5] = ~w_wr_word[5];
        end
      end
      assign {w_db, w_sb, w_rd_data} = f_dec(r_rd_word);
    end else begin : g_raw
      assign w_wr_word = bus.wrData;
      assign w_rd_data = r_rd_word;
      assign w_sb      = 1'b0;
      assign w_db      = 1'b0;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (w_wacc) r_mem[r_wsel][bus.wrAddr] <= w_wr_word;
    if (w_racc) r_rd_word <= r_mem[r_rsel][bus.rdAddr];
  end

  // Write side acts first so a same-cycle commit sees the new count.
  always_comb begin
    n_st   = r_st;
    n_cnt  = r_cnt;
    n_wsel = r_wsel;
    n_rsel = r_rsel;
    n_perr = '0;
    w_sum  = '0;
    if (bus.wrEn && !w_wr_ready) n_perr[0] = 1'b1;
    if (w_wacc) begin
      if (r_st[r_wsel] == S_FREE) n_st[r_wsel] = S_FILL;
      w_sum = {1'b0, r_cnt[r_wsel]} + (CW+1)'(bus.wrByteCnt);
      n_cnt[r_wsel] = (w_sum > (CW+1)'(MAXB)) ? CW'(MAXB) : w_sum[CW-1:0];
    end
    if (bus.wrCommit) begin
      if ((n_st[r_wsel] == S_FILL) && (n_cnt[r_wsel] != '0)) begin
        n_st[r_wsel] = S_READY;
        n_wsel       = f_next(r_wsel);
      end else begin
        n_perr[2] = 1'b1;
      end
    end
    if (bus.rdEn && !w_rd_ready) n_perr[1] = 1'b1;
    if (w_racc) begin
      if (r_st[r_rsel] == S_READY) n_st[r_rsel] = S_DRAIN;
      if (CW'(bus.rdByteCnt) > r_cnt[r_rsel]) begin
        n_cnt[r_rsel] = '0;
        n_perr[1]     = 1'b1;
      end else begin
        n_cnt[r_rsel] = r_cnt[r_rsel] - CW'(bus.rdByteCnt);
      end
    end
    if (bus.rdRelease) begin
      if (w_rd_ready) begin
        n_st[r_rsel]  = S_FREE;
        n_cnt[r_rsel] = '0;
        n_rsel        = f_next(r_rsel);
      end else begin
        n_perr[1] = 1'b1;
      end
    end
    n_free = '0;
    for (int i = 0; i < NUM_BANKS; i++)
      if (n_st[i] == S_FREE) n_free = n_free + (BW+1)'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_st[i]  <= S_FREE;
        r_cnt[i] <= '0;
      end
      r_wsel  <= '0;
      r_rsel  <= '0;
      r_free  <= (BW+1)'(NUM_BANKS);
      r_perr  <= '0;
      r_v1    <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_sb    <= 1'b0;
      r_db    <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_st[i]  <= S_FREE;
        r_cnt[i] <= '0;
      end
      r_wsel  <= '0;
      r_rsel  <= '0;
      r_free  <= (BW+1)'(NUM_BANKS);
      r_perr  <= '0;
      r_v1    <= 1'b0;
      r_valid <= 1'b0;
      r_sb    <= 1'b0;
      r_db    <= 1'b0;
    end else begin
      r_st    <= n_st;
      r_cnt   <= n_cnt;
      r_wsel  <= n_wsel;
      r_rsel  <= n_rsel;
      r_free  <= n_free;
      r_perr  <= n_perr;
      r_v1    <= w_racc;
      r_valid <= r_v1;
      if (r_v1) r_rdata <= w_rd_data;
      r_sb    <= r_v1 & w_sb;
      r_db    <= r_v1 & w_db;
    end
  end

  assign bus.wrBankSel           = r_wsel;
  assign bus.rdBankSel           = r_rsel;
  assign bus.wrReady             = w_wr_ready;
  assign bus.rdReady             = w_rd_ready;
  assign bus.wrBankByteCnt       = r_cnt[r_wsel];
  assign bus.rdBankByteCnt       = r_cnt[r_rsel];
  assign bus.freeBanks           = r_free;
  assign bus.rdData              = r_rdata;
  assign bus.rdValid             = r_valid;
  assign bus.protoErr            = r_perr;
  assign bus.error_flag_sb_cache = r_sb;
  assign bus.error_flag_db_cache = r_db;

endmodule

// File: tb/tb_coreaxi4dma_multibank_cache.sv
// tb_coreaxi4dma_multibank_cache: directed checks of the bank ring,
// read latency, protocol error pulses, ECC flags, flush and async reset.
module tb_coreaxi4dma_multibank_cache;
  localparam int W = 8;
  localparam int D = 16;
  localparam int N = 4;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  coreaxi4dma_multibank_cache_if #(
    .CACHE_WIDTH(W), .CACHE_DEPTH(D), .NUM_BANKS(N)
  ) bus ();

  coreaxi4dma_multibank_cache #(
    .CACHE_WIDTH(W), .CACHE_DEPTH(D), .NUM_BANKS(N), .ECC(1)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [63:0] d,
                    input logic [3:0] n, input logic [1:0] inj,
                    input logic cm);
    bus.wrEn      = 1'b1;
    bus.wrAddr    = a;
    bus.wrData    = d;
    bus.wrByteCnt = n;
    bus.wrEccInj  = inj;
    bus.wrCommit  = cm;
    step();
    bus.wrEn     = 1'b0;
    bus.wrCommit = 1'b0;
    bus.wrEccInj = 2'b00;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] n);
    bus.rdEn      = 1'b1;
    bus.rdAddr    = a;
    bus.rdByteCnt = n;
    step();
    bus.rdEn = 1'b0;
  endtask

  task automatic commit();
    bus.wrCommit = 1'b1;
    step();
    bus.wrCommit = 1'b0;
  endtask

  task automatic rel();
    bus.rdRelease = 1'b1;
    step();
    bus.rdRelease = 1'b0;
  endtask

  function automatic logic [63:0] dpat(input int i);
    return 64'h0123_4567_89AB_CD00 + 64'(i);
  endfunction

  localparam logic [63:0] C5 = 64'hCAFE_F00D_1234_5678;
  localparam logic [63:0] E1 = 64'h0F0F_1234_5678_9ABC;
  localparam logic [63:0] E2 = 64'h55AA_33CC_0FF0_A5A5;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.flush = 1'b0; bus.wrEn = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    bus.wrByteCnt = '0; bus.wrCommit = 1'b0; bus.wrEccInj = 2'b00;
    bus.rdEn = 1'b0; bus.rdAddr = '0; bus.rdByteCnt = '0;
    bus.rdRelease = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_wsel", bus.wrBankSel, 0);
    chk("rst_rsel", bus.rdBankSel, 0);
    chk("rst_wrReady", bus.wrReady, 1);
    chk("rst_rdReady", bus.rdReady, 0);
    chk("rst_free", bus.freeBanks, 4);
    chk("rst_rdValid", bus.rdValid, 0);
    chk("rst_rdData", bus.rdData, 0);
    chk("rst_perr", bus.protoErr, 0);
    chk("rst_ecc", {bus.error_flag_sb_cache, bus.error_flag_db_cache}, 0);
    chk("rst_wcnt", bus.wrBankByteCnt, 0);

    // fill bank 0 and commit
    for (int i = 0; i < 4; i++) wr(4'(i), dpat(i), 4'd8, 2'b00, 1'b0);
    chk("fill_wcnt", bus.wrBankByteCnt, 32);
    chk("fill_free", bus.freeBanks, 3);
    chk("fill_rdReady", bus.rdReady, 0);
    commit();
    chk("cm_wsel", bus.wrBankSel, 1);
    chk("cm_rdReady", bus.rdReady, 1);
    chk("cm_rcnt", bus.rdBankByteCnt, 32);
    chk("cm_perr", bus.protoErr, 0);

    // single reads, 2-cycle latency
    rd(4'd0, 4'd8);
    chk("rd0_lat1", bus.rdValid, 0);
    chk("rd0_rcnt", bus.rdBankByteCnt, 24);
    step();
    chk("rd0_valid", bus.rdValid, 1);
    chk("rd0_data", bus.rdData, dpat(0));
    rd(4'd1, 4'd8);
    step();
    chk("rd1_valid", bus.rdValid, 1);
    chk("rd1_data", bus.rdData, dpat(1));

    // back-to-back reads
    bus.rdEn = 1'b1; bus.rdAddr = 4'd2; bus.rdByteCnt = 4'd8;
    step();
    bus.rdAddr = 4'd3;
    step();
    bus.rdEn = 1'b0;
    chk("b2b_v2", bus.rdValid, 1);
    chk("b2b_d2", bus.rdData, dpat(2));
    step();
    chk("b2b_v3", bus.rdValid, 1);
    chk("b2b_d3", bus.rdData, dpat(3));
    step();
    chk("b2b_end", bus.rdValid, 0);
    chk("b2b_hold", bus.rdData, dpat(3));
    chk("drain_rcnt", bus.rdBankByteCnt, 0);
    rel();
    chk("rel_rsel", bus.rdBankSel, 1);
    chk("rel_rdReady", bus.rdReady, 0);
    step();
    chk("rel_free", bus.freeBanks, 4);

    // ring full
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl0_wsel", bus.wrBankSel, 0);
    for (int b = 0; b < 4; b++) wr(4'd0, 64'h1000 + 64'(b), 4'd8, 2'b00, 1'b1);
    chk("full_wrReady", bus.wrReady, 0);
    chk("full_wsel", bus.wrBankSel, 0);
    chk("full_free", bus.freeBanks, 0);
    bus.wrEn = 1'b1;
    step();
    bus.wrEn = 1'b0;
    chk("full_drop", bus.protoErr, 3'b001);
    chk("full_wcnt", bus.wrBankByteCnt, 8);
    step();
    chk("full_pulse", bus.protoErr, 0);
    rel();
    chk("wrap_wrReady", bus.wrReady, 1);
    chk("wrap_wsel", bus.wrBankSel, 0);
    chk("wrap_rsel", bus.rdBankSel, 1);

    // empty commit, then write+commit on a FREE bank
    commit();
    chk("empty_cm", bus.protoErr, 3'b100);
    chk("empty_wsel", bus.wrBankSel, 0);
    step();
    chk("empty_pulse", bus.protoErr, 0);
    wr(4'd1, C5, 4'd5, 2'b00, 1'b1);
    chk("wc_wsel", bus.wrBankSel, 1);
    chk("wc_wrReady", bus.wrReady, 0);
    rel(); rel(); rel();
    chk("wc_rsel", bus.rdBankSel, 0);
    chk("wc_rcnt", bus.rdBankByteCnt, 5);

    // underflow and read on a non-ready bank
    rd(4'd1, 4'd8);
    chk("uf_perr", bus.protoErr, 3'b010);
    chk("uf_rcnt", bus.rdBankByteCnt, 0);
    step();
    chk("uf_data", bus.rdData, C5);
    chk("uf_pulse", bus.protoErr, 0);
    rel();
    chk("nr_rdReady", bus.rdReady, 0);
    rd(4'd0, 4'd8);
    chk("nr_perr", bus.protoErr, 3'b010);
    step();
    chk("nr_v1", bus.rdValid, 0);
    step();
    chk("nr_v2", bus.rdValid, 0);

    // ECC single and double bit errors
    wr(4'd2, E1, 4'd8, 2'b01, 1'b0);
    wr(4'd3, E2, 4'd8, 2'b10, 1'b1);
    chk("ecc_rdReady", bus.rdReady, 1);
    rd(4'd2, 4'd8);
    chk("sb_early", bus.error_flag_sb_cache, 0);
    step();
    chk("sb_valid", bus.rdValid, 1);
    chk("sb_flags", {bus.error_flag_sb_cache, bus.error_flag_db_cache}, 2'b10);
    chk("sb_data", bus.rdData, E1);
    step();
    chk("sb_after", bus.error_flag_sb_cache, 0);
    rd(4'd3, 4'd8);
    step();
    chk("db_flags", {bus.error_flag_sb_cache, bus.error_flag_db_cache}, 2'b01);
    step();
    chk("db_after", bus.error_flag_db_cache, 0);

    // flush with a read in flight and two banks READY
    wr(4'd0, 64'hAAAA, 4'd8, 2'b00, 1'b1);
    wr(4'd0, 64'hBBBB, 4'd8, 2'b00, 1'b1);
    chk("pre_fl_free", bus.freeBanks, 1);
    rd(4'd0, 4'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_valid", bus.rdValid, 0);
    chk("fl_wsel", bus.wrBankSel, 0);
    chk("fl_rsel", bus.rdBankSel, 0);
    chk("fl_free", bus.freeBanks, 4);
    chk("fl_wcnt", bus.wrBankByteCnt, 0);
    chk("fl_rcnt", bus.rdBankByteCnt, 0);
    step();
    chk("fl_valid2", bus.rdValid, 0);

    // async reset mid-write
    wr(4'd0, 64'h1234, 4'd8, 2'b00, 1'b0);
    chk("ar_wcnt_pre", bus.wrBankByteCnt, 8);
    chk("ar_free_pre", bus.freeBanks, 3);
    bus.wrEn = 1'b1;
    rst = 1'b1;
    #2;
    chk("ar_wcnt", bus.wrBankByteCnt, 0);
    chk("ar_free", bus.freeBanks, 4);
    chk("ar_wrReady", bus.wrReady, 1);
    chk("ar_perr", bus.protoErr, 0);
    bus.wrEn = 1'b0;
    step();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
